// File: rtl/vector_addsub_series.sv
// Series-multiplexed signed vector adder/subtractor.
// A vector of LANES*SERIES elements arrives as SERIES beats of LANES
// elements. Each beat is added or subtracted lane-wise into a registered
// result. The add/sub mode is taken from the first beat of each vector.
// Optional macro VECTOR_ADDSUB_PIPE2_EN adds a second output register
// stage, giving two cycles of latency and a registered earlyOutReady.
module vector_addsub_series #(
   parameter int IN_WIDTH = 10,
   parameter int LANES    = 5,
   parameter int SERIES   = 2,
   localparam int SW      = (SERIES > 1) ? $clog2(SERIES) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          inReady,
   input  logic                          sub,
   input  logic [LANES*IN_WIDTH-1:0]     A,
   input  logic [LANES*IN_WIDTH-1:0]     B,
   output logic                          readyForNewDataSeries,
   output logic [SW-1:0]                 inSeries,
   output logic                          earlyOutReady,
   output logic                          outReady,
   output logic [SW-1:0]                 outSeries,
   output logic                          outLast,
   output logic [LANES*(IN_WIDTH+1)-1:0] S
);

   localparam int OW = IN_WIDTH + 1;
   localparam logic [SW-1:0] LAST_IDX = SW'(SERIES - 1);

   logic                  accept;
   logic                  modeReg;
   logic                  useSub;
   logic [SW-1:0]         outNextSeries;
   logic [LANES*OW-1:0]   laneResult;
   logic                  resultValid;
   logic [LANES*OW-1:0]   resultData;

   // Advance a series index, wrapping after the last beat of a vector
   function automatic logic [SW-1:0] wrapInc(input logic [SW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Reset wins over a simultaneous beat, so the beat is dropped
   assign accept = enable & inReady & ~reset;

   // The first beat of a vector uses the live mode; later beats reuse the latched one
   assign useSub = (inSeries == '0) ? sub : modeReg;

   assign outNextSeries = wrapInc(outSeries);

   // Sign-extend each lane by one bit so the sum or difference is always exact
   for (genvar k = 0; k < LANES; k++) begin : gLane
      logic signed [OW-1:0] aExt;
      logic signed [OW-1:0] bExt;
      assign aExt = {A[k*IN_WIDTH+IN_WIDTH-1], A[k*IN_WIDTH +: IN_WIDTH]};
      assign bExt = {B[k*IN_WIDTH+IN_WIDTH-1], B[k*IN_WIDTH +: IN_WIDTH]};
      assign laneResult[k*OW +: OW] = useSub ? (aExt - bExt) : (aExt + bExt);
   end

   // Input series counter, new-vector flag and latched mode
   always_ff @(posedge clk) begin
      if (reset) begin
         inSeries              <= '0;
         readyForNewDataSeries <= 1'b1;
         modeReg               <= 1'b0;
      end else if (accept) begin
         inSeries              <= wrapInc(inSeries);
         readyForNewDataSeries <= (wrapInc(inSeries) == '0);
         if (inSeries == '0) begin
            modeReg <= sub;
         end
      end
   end

`ifdef VECTOR_ADDSUB_PIPE2_EN
   logic                stageValid;
   logic [LANES*OW-1:0] stageData;

   // First pipeline stage holds the raw lane results of an accepted beat
   always_ff @(posedge clk) begin
      if (reset) begin
         stageValid <= 1'b0;
         stageData  <= '0;
      end else if (enable) begin
         stageValid <= accept;
         if (accept) begin
            stageData <= laneResult;
         end
      end
   end

   assign resultValid   = stageValid;
   assign resultData    = stageData;
   assign earlyOutReady = stageValid;
`else
   assign resultValid   = accept;
   assign resultData    = laneResult;
   assign earlyOutReady = accept;
`endif

   // Output stage: result, valid pulse and series tag travel together
   always_ff @(posedge clk) begin
      if (reset) begin
         S         <= '0;
         outReady  <= 1'b0;
         outSeries <= LAST_IDX;
         outLast   <= 1'b0;
      end else if (enable) begin
         outReady <= resultValid;
         if (resultValid) begin
            S         <= resultData;
            outSeries <= outNextSeries;
            outLast   <= (outNextSeries == LAST_IDX);
         end
      end
   end

endmodule

// File: tb/tb_vector_addsub_series.sv
// Directed testbench for vector_addsub_series with default parameters.
// Expected results are hand-computed constants; latency follows
// VECTOR_ADDSUB_PIPE2_EN when that macro is defined.
module tb_vector_addsub_series;

   localparam int W  = 10;
   localparam int OW = 11;
   localparam int L  = 5;
`ifdef VECTOR_ADDSUB_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk;
   logic            reset;
   logic            enable;
   logic            inReady;
   logic            sub;
   logic [L*W-1:0]  A;
   logic [L*W-1:0]  B;
   logic            readyForNewDataSeries;
   logic [0:0]      inSeries;
   logic            earlyOutReady;
   logic            outReady;
   logic [0:0]      outSeries;
   logic            outLast;
   logic [L*OW-1:0] S;

   int checks;
   int failures;

   vector_addsub_series #(.IN_WIDTH(W), .LANES(L), .SERIES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .inReady(inReady), .sub(sub),
      .A(A), .B(B), .readyForNewDataSeries(readyForNewDataSeries),
      .inSeries(inSeries), .earlyOutReady(earlyOutReady), .outReady(outReady),
      .outSeries(outSeries), .outLast(outLast), .S(S)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [L*W-1:0] fillIn(input int v);
      logic [L*W-1:0] r;
      for (int k = 0; k < L; k++) r[k*W +: W] = v[W-1:0];
      return r;
   endfunction

   function automatic logic [L*OW-1:0] fillOut(input int v);
      logic [L*OW-1:0] r;
      for (int k = 0; k < L; k++) r[k*OW +: OW] = v[OW-1:0];
      return r;
   endfunction

   function automatic logic [L*W-1:0] packIn(input int v0, v1, v2, v3, v4);
      logic [L*W-1:0] r;
      r = {v4[W-1:0], v3[W-1:0], v2[W-1:0], v1[W-1:0], v0[W-1:0]};
      return r;
   endfunction

   function automatic logic [L*OW-1:0] packOut(input int v0, v1, v2, v3, v4);
      logic [L*OW-1:0] r;
      r = {v4[OW-1:0], v3[OW-1:0], v2[OW-1:0], v1[OW-1:0], v0[OW-1:0]};
      return r;
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Present one beat for one cycle, then idle until its result is on S
   task automatic applyStimulus(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic s);
      A = a; B = b; sub = s; inReady = 1'b1;
      stepCycle();
      inReady = 1'b0;
      repeat (LAT - 1) stepCycle();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; inReady = 1'b0; sub = 1'b0; A = '0; B = '0;
      repeat (2) stepCycle();
      reset = 1'b0;
      stepCycle();
      checks++;
      if (readyForNewDataSeries !== 1'b1) begin failures++; $display("[TB] FAIL reset_rfnds got=%0b exp=1", readyForNewDataSeries); end
      checks++;
      if (inSeries !== 1'b0) begin failures++; $display("[TB] FAIL reset_inSeries got=%0d exp=0", inSeries); end
      checks++;
      if (outSeries !== 1'b1) begin failures++; $display("[TB] FAIL reset_outSeries got=%0d exp=1", outSeries); end
      checks++;
      if (outReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_outReady got=%0b exp=0", outReady); end
      checks++;
      if (S !== '0) begin failures++; $display("[TB] FAIL reset_S got=%0h exp=0", S); end
   endtask

   task automatic test_add();
      A = packIn(1, 2, 3, 4, 5); B = packIn(10, 20, 30, 40, 50); sub = 1'b0; inReady = 1'b1;
      #1;
`ifndef VECTOR_ADDSUB_PIPE2_EN
      checks++;
      if (earlyOutReady !== 1'b1) begin failures++; $display("[TB] FAIL add_early got=%0b exp=1", earlyOutReady); end
`endif
      stepCycle();
      inReady = 1'b0;
`ifdef VECTOR_ADDSUB_PIPE2_EN
      checks++;
      if (earlyOutReady !== 1'b1 || outReady !== 1'b0) begin failures++; $display("[TB] FAIL add_early_pipe got=%0b/%0b exp=1/0", earlyOutReady, outReady); end
      stepCycle();
`endif
      checks++;
      if (outReady !== 1'b1) begin failures++; $display("[TB] FAIL add0_outReady got=%0b exp=1", outReady); end
      checks++;
      if (S !== packOut(11, 22, 33, 44, 55)) begin failures++; $display("[TB] FAIL add0_S got=%0h exp=%0h", S, packOut(11, 22, 33, 44, 55)); end
      checks++;
      if (outSeries !== 1'b0 || outLast !== 1'b0) begin failures++; $display("[TB] FAIL add0_tag got=%0d/%0b exp=0/0", outSeries, outLast); end
      checks++;
      if (inSeries !== 1'b1 || readyForNewDataSeries !== 1'b0) begin failures++; $display("[TB] FAIL add0_inSeries got=%0d/%0b exp=1/0", inSeries, readyForNewDataSeries); end
      applyStimulus(fillIn(-512), fillIn(-512), 1'b0);
      checks++;
      if (S !== fillOut(-1024)) begin failures++; $display("[TB] FAIL add1_S got=%0h exp=%0h", S, fillOut(-1024)); end
      checks++;
      if (outSeries !== 1'b1 || outLast !== 1'b1) begin failures++; $display("[TB] FAIL add1_tag got=%0d/%0b exp=1/1", outSeries, outLast); end
      stepCycle();
      checks++;
      if (outReady !== 1'b0 || S !== fillOut(-1024)) begin failures++; $display("[TB] FAIL add_hold got=%0b/%0h exp=0/%0h", outReady, S, fillOut(-1024)); end
   endtask

   task automatic test_mode_latch();
      applyStimulus(fillIn(511), fillIn(-512), 1'b1);
      checks++;
      if (S !== fillOut(1023)) begin failures++; $display("[TB] FAIL mode0_S got=%0h exp=%0h", S, fillOut(1023)); end
      applyStimulus(fillIn(511), fillIn(-512), 1'b0);
      checks++;
      if (S !== fillOut(1023)) begin failures++; $display("[TB] FAIL mode1_S got=%0h exp=%0h", S, fillOut(1023)); end
   endtask

   task automatic test_back_to_back();
      int r;
      for (int cyc = 0; cyc < 6 + LAT; cyc++) begin
         if (cyc < 6) begin
            A = fillIn(cyc + 1); B = fillIn(100); sub = 1'b0; inReady = 1'b1;
         end else begin
            inReady = 1'b0;
         end
         stepCycle();
         r = cyc - (LAT - 1);
         if (r >= 0 && r < 6) begin
            checks++;
            if (outReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_outReady[%0d] got=%0b exp=1", r, outReady); end
            checks++;
            if (outSeries !== 1'(r % 2) || outLast !== 1'(r % 2)) begin failures++; $display("[TB] FAIL b2b_tag[%0d] got=%0d/%0b exp=%0d/%0d", r, outSeries, outLast, r % 2, r % 2); end
            checks++;
            if (S !== fillOut(r + 101)) begin failures++; $display("[TB] FAIL b2b_S[%0d] got=%0h exp=%0h", r, S, fillOut(r + 101)); end
         end
      end
      stepCycle();
      checks++;
      if (outReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end got=%0b exp=0", outReady); end
   endtask

   task automatic test_enable_hold();
      applyStimulus(fillIn(7), fillIn(3), 1'b1);
      enable = 1'b0; inReady = 1'b1; sub = 1'b0; A = fillIn(100); B = fillIn(100);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checks++;
         if (outReady !== 1'b1 || S !== fillOut(4)) begin failures++; $display("[TB] FAIL hold_out[%0d] got=%0b/%0h exp=1/%0h", i, outReady, S, fillOut(4)); end
         checks++;
         if (inSeries !== 1'b1 || readyForNewDataSeries !== 1'b0 || outSeries !== 1'b0) begin failures++; $display("[TB] FAIL hold_cnt[%0d] got=%0d/%0b/%0d exp=1/0/0", i, inSeries, readyForNewDataSeries, outSeries); end
      end
      enable = 1'b1; inReady = 1'b0;
      applyStimulus(fillIn(7), fillIn(3), 1'b0);
      checks++;
      if (S !== fillOut(4) || outSeries !== 1'b1 || outLast !== 1'b1) begin failures++; $display("[TB] FAIL resume got=%0h/%0d/%0b exp=%0h/1/1", S, outSeries, outLast, fillOut(4)); end
      checks++;
      if (inSeries !== 1'b0) begin failures++; $display("[TB] FAIL resume_inSeries got=%0d exp=0", inSeries); end
   endtask

   task automatic test_reset_mid_vector();
      applyStimulus(fillIn(5), fillIn(2), 1'b1);
      checks++;
      if (S !== fillOut(3)) begin failures++; $display("[TB] FAIL rmid_first got=%0h exp=%0h", S, fillOut(3)); end
      reset = 1'b1; inReady = 1'b1; sub = 1'b1;
      stepCycle();
      reset = 1'b0; inReady = 1'b0;
      checks++;
      if (inSeries !== 1'b0 || readyForNewDataSeries !== 1'b1) begin failures++; $display("[TB] FAIL rmid_in got=%0d/%0b exp=0/1", inSeries, readyForNewDataSeries); end
      checks++;
      if (outReady !== 1'b0 || outLast !== 1'b0 || S !== '0 || outSeries !== 1'b1) begin failures++; $display("[TB] FAIL rmid_out got=%0b/%0b/%0h/%0d exp=0/0/0/1", outReady, outLast, S, outSeries); end
      stepCycle();
      checks++;
      if (outReady !== 1'b0 || inSeries !== 1'b0) begin failures++; $display("[TB] FAIL rmid_drop got=%0b/%0d exp=0/0", outReady, inSeries); end
      applyStimulus(fillIn(5), fillIn(2), 1'b0);
      checks++;
      if (S !== fillOut(7) || outSeries !== 1'b0 || outLast !== 1'b0) begin failures++; $display("[TB] FAIL rmid_next got=%0h/%0d/%0b exp=%0h/0/0", S, outSeries, outLast, fillOut(7)); end
   endtask

   // Run every scenario in order, then report
   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_add();
      test_mode_latch();
      test_back_to_back();
      test_enable_hold();
      test_reset_mid_vector();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
